toeplitz_row_accum: RTL and testbench

TOEPLITZ_ROW_ACCUM -- requirements
Module: toeplitz_row_accum

---
 rtl/toeplitz_row_accum.sv | 118 +++++++++++
 tb/tb_toeplitz_row_accum.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/toeplitz_row_accum.sv
// Toeplitz row accumulator: XOR-accumulates matrix rows selected by the
// paired input-vector bit over a block of N_ROWS beats, then holds the
// hash until the downstream accepts it.
module toeplitz_row_accum #(
  parameter int ROW_W  = 3072,
  parameter int N_ROWS = 4096,
  parameter int CNT_W  = 13
) (
  input  logic             clk_in,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             seed_en,
  input  logic [ROW_W-1:0] seed,
  input  logic             row_valid,
  input  logic [ROW_W-1:0] row,
  input  logic             coeff,
  output logic             row_ready,
  output logic             result_valid,
  output logic [ROW_W-1:0] result,
  input  logic             result_ready,
  output logic             busy,
  output logic [CNT_W-1:0] rows_done
);

  if ((N_ROWS < 1) || ((64'd1 << CNT_W) <= 64'(N_ROWS))) begin : g_param_check
    $error("toeplitz_row_accum: need N_ROWS >= 1 and 2**CNT_W > N_ROWS");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    OUT  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_ROWS - 1);

  state_t           state_q, state_d;
  logic [ROW_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             beat;

  // State, accumulator and row counter registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; abort overrides every other event in any state.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    beat    = row_valid && (state_q == ACC);

    if (abort) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_d = ACC;
            acc_d   = seed_en ? seed : '0;
            cnt_d   = '0;
          end
        end
        ACC: begin
          if (beat) begin
            if (coeff) begin
              acc_d = acc_q ^ row;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == LAST_CNT) begin
              state_d = OUT;
            end
          end
        end
        OUT: begin
          // Accepting the result with start asserted chains straight into
          // the next block without passing through IDLE.
          if (result_ready) begin
            if (start) begin
              state_d = ACC;
              acc_d   = seed_en ? seed : '0;
              cnt_d   = '0;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Handshake and status outputs decoded from the registered state only.
  always_comb begin
    row_ready    = (state_q == ACC);
    result_valid = (state_q == OUT);
    busy         = (state_q != IDLE);
    result       = acc_q;
    rows_done    = cnt_q;
  end

endmodule

// File: tb/tb_toeplitz_row_accum.sv
// Directed self-checking bench for toeplitz_row_accum: a small 8-bit,
// 4-row instance for the main scenarios plus a wide single-row instance.
module tb_toeplitz_row_accum;

  logic clk;
  logic rst;

  // Small instance: ROW_W=8, N_ROWS=4
  logic       start, abort, seed_en, row_valid, coeff, result_ready;
  logic [7:0] seed, row;
  logic       row_ready, result_valid, busy;
  logic [7:0] result;
  logic [2:0] rows_done;

  // Wide instance: ROW_W=3072, N_ROWS=1
  logic          w_start, w_abort, w_seed_en, w_row_valid, w_coeff, w_result_ready;
  logic [3071:0] w_seed, w_row;
  logic          w_row_ready, w_result_valid, w_busy;
  logic [3071:0] w_result;
  logic [0:0]    w_rows_done;
  logic [3071:0] w_ones;

  int checks;
  int errors;

  toeplitz_row_accum #(.ROW_W(8), .N_ROWS(4), .CNT_W(3)) dut (
    .clk_in(clk), .rst(rst), .start(start), .abort(abort), .seed_en(seed_en),
    .seed(seed), .row_valid(row_valid), .row(row), .coeff(coeff),
    .row_ready(row_ready), .result_valid(result_valid), .result(result),
    .result_ready(result_ready), .busy(busy), .rows_done(rows_done)
  );

  toeplitz_row_accum #(.ROW_W(3072), .N_ROWS(1), .CNT_W(1)) dut_w (
    .clk_in(clk), .rst(rst), .start(w_start), .abort(w_abort), .seed_en(w_seed_en),
    .seed(w_seed), .row_valid(w_row_valid), .row(w_row), .coeff(w_coeff),
    .row_ready(w_row_ready), .result_valid(w_result_valid), .result(w_result),
    .result_ready(w_result_ready), .busy(w_busy), .rows_done(w_rows_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_status(input string tag, input logic rr, input logic rv,
                            input logic bz, input logic [7:0] res, input logic [2:0] cnt);
    chk({tag, ".row_ready"}, 32'(row_ready), 32'(rr));
    chk({tag, ".result_valid"}, 32'(result_valid), 32'(rv));
    chk({tag, ".busy"}, 32'(busy), 32'(bz));
    chk({tag, ".result"}, 32'(result), 32'(res));
    chk({tag, ".rows_done"}, 32'(rows_done), 32'(cnt));
  endtask

  // One accepted beat on the small instance.
  task automatic do_beat(input logic [7:0] r, input logic c);
    row_valid = 1'b1;
    row       = r;
    coeff     = c;
    tick();
    row_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    start = 0; abort = 0; seed_en = 0; seed = '0; row_valid = 0; row = '0;
    coeff = 0; result_ready = 0;
    w_start = 0; w_abort = 0; w_seed_en = 0; w_seed = '0; w_row_valid = 0;
    w_row = '0; w_coeff = 0; w_result_ready = 0;
    w_ones = '1;

    // Reset state
    rst = 1'b1;
    #1;
    chk_status("reset", 0, 0, 0, 8'h00, 3'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    chk_status("idle_after_reset", 0, 0, 0, 8'h00, 3'd0);

    // Plain block, seed_en=0, back-to-back beats
    start = 1; seed_en = 0;
    tick();
    start = 0;
    chk_status("b1_start", 1, 0, 1, 8'h00, 3'd0);
    row_valid = 1;
    row = 8'h01; coeff = 1; tick();
    row = 8'h02; coeff = 0; tick();
    row = 8'h04; coeff = 1; tick();
    chk_status("b1_beat3", 1, 0, 1, 8'h05, 3'd3);
    row = 8'h08; coeff = 1; tick();
    row_valid = 0;
    chk_status("b1_done", 0, 1, 1, 8'h0D, 3'd4);
    tick();
    chk_status("b1_hold", 0, 1, 1, 8'h0D, 3'd4);
    result_ready = 1;
    tick();
    result_ready = 0;
    chk_status("b1_accepted", 0, 0, 0, 8'h0D, 3'd4);

    // Seeded block with stalls between beats and a held-off result
    start = 1; seed_en = 1; seed = 8'hF0;
    tick();
    start = 0; seed_en = 0; seed = 8'h00;
    chk_status("b2_start", 1, 0, 1, 8'hF0, 3'd0);
    do_beat(8'h01, 1);
    for (int k = 0; k < 3; k++) tick();
    chk_status("b2_stall1", 1, 0, 1, 8'hF1, 3'd1);
    do_beat(8'h02, 0);
    for (int k = 0; k < 3; k++) tick();
    chk_status("b2_stall2", 1, 0, 1, 8'hF1, 3'd2);
    do_beat(8'h04, 1);
    for (int k = 0; k < 3; k++) tick();
    chk_status("b2_stall3", 1, 0, 1, 8'hF5, 3'd3);
    do_beat(8'h08, 1);
    chk_status("b2_done", 0, 1, 1, 8'hFD, 3'd4);
    // Offer extra beats while the result waits; none may be taken.
    row_valid = 1; row = 8'hAA; coeff = 1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_status("b2_wait", 0, 1, 1, 8'hFD, 3'd4);
    end
    row_valid = 0;

    // Accept and start the next block in the same cycle
    result_ready = 1; start = 1; seed_en = 0; seed = 8'h33;
    tick();
    result_ready = 0; start = 0;
    chk_status("b3_chain", 1, 0, 1, 8'h00, 3'd0);
    row_valid = 1; row = 8'hFF;
    coeff = 1; tick();
    coeff = 1; tick();
    coeff = 1; tick();
    coeff = 0; tick();
    row_valid = 0;
    chk_status("b3_done", 0, 1, 1, 8'hFF, 3'd4);
    result_ready = 1;
    tick();
    result_ready = 0;
    chk_status("b3_accepted", 0, 0, 0, 8'hFF, 3'd4);

    // Abort on the final beat; start during ACC is ignored
    start = 1; seed_en = 1; seed = 8'h55;
    tick();
    start = 0; seed_en = 0;
    do_beat(8'h11, 1);
    start = 1;
    do_beat(8'h22, 1);
    start = 0;
    do_beat(8'h44, 0);
    chk_status("b4_beat3", 1, 0, 1, 8'h66, 3'd3);
    abort = 1;
    do_beat(8'h80, 1);
    abort = 0;
    chk_status("b4_aborted", 0, 0, 0, 8'h00, 3'd0);
    tick();
    chk_status("b4_idle", 0, 0, 0, 8'h00, 3'd0);

    // Asynchronous reset mid-block
    start = 1;
    tick();
    start = 0;
    do_beat(8'h03, 1);
    do_beat(8'h0C, 1);
    chk_status("b5_two_beats", 1, 0, 1, 8'h0F, 3'd2);
    #2 rst = 1;
    #1;
    chk_status("b5_async_rst", 0, 0, 0, 8'h00, 3'd0);
    #2 rst = 0;
    row_valid = 1; row = 8'hFF; coeff = 1;
    tick();
    tick();
    chk_status("b5_no_start", 0, 0, 0, 8'h00, 3'd0);
    row_valid = 0;

    // Wide single-row instance
    checks++;
    assert (w_result === '0) else begin
      errors++;
      $error("FAIL w_idle.result observed=%0h expected=0", w_result[31:0]);
    end
    w_start = 1;
    tick();
    w_start = 0;
    chk("w_start.row_ready", 32'(w_row_ready), 32'd1);
    w_row_valid = 1; w_row = w_ones; w_coeff = 1;
    tick();
    w_row_valid = 0;
    chk("w_done.result_valid", 32'(w_result_valid), 32'd1);
    chk("w_done.rows_done", 32'(w_rows_done), 32'd1);
    checks++;
    assert (w_result === w_ones) else begin
      errors++;
      $error("FAIL w_done.result observed_low=%0h expected=all-ones", w_result[31:0]);
    end
    w_result_ready = 1;
    tick();
    w_result_ready = 0;
    chk("w_accepted.busy", 32'(w_busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
